// File: rtl/reg_file_pkg.sv
// Shared types for the register file: clear-engine state encoding.
package reg_file_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } clr_state_e;

endpackage

// File: rtl/reg_file.sv
// Multi-entry register file: one write port, two combinational read ports,
// optional write-to-read bypass and hardwired-zero entry, plus a one-entry-per-cycle clear engine.
module reg_file
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter bit ZERO_REG = 1'b0,
    parameter bit BYPASS   = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_b,
    input  logic              clr_req,
    output logic              busy,
    output logic              clr_done
);

    clr_state_e                      state_reg;
    logic [ADDR_W-1:0]               idx_reg;
    logic                            busy_reg;
    logic                            clr_done_reg;
    logic [NUM_REGS-1:0][DATA_W-1:0] entry_flat;

    logic                            is_idle;
    logic                            wr_fwd;
    logic                            wr_commit;
    logic                            sweep_last;

    // Non-power-of-2 depths leave address codes with no backing entry.
    function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr);
        return int'(addr) < NUM_REGS;
    endfunction

    function automatic logic addr_is_zero_reg(input logic [ADDR_W-1:0] addr);
        return ZERO_REG && (addr == '0);
    endfunction

    assign is_idle    = (state_reg == IDLE);
    // A write that would land: eligible for bypass even if a same-cycle clear drops it.
    assign wr_fwd     = is_idle && we && addr_in_range(waddr) && !addr_is_zero_reg(waddr);
    assign wr_commit  = wr_fwd && !clr_req;
    assign sweep_last = (idx_reg == ADDR_W'(NUM_REGS - 1));

    // Clear engine: busy/clr_done are registered alongside the state they decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            idx_reg      <= '0;
            busy_reg     <= 1'b0;
            clr_done_reg <= 1'b0;
        end else begin
            unique case (state_reg)
                IDLE: begin
                    clr_done_reg <= 1'b0;
                    if (clr_req) begin
                        state_reg <= SWEEP;
                        idx_reg   <= '0;
                        busy_reg  <= 1'b1;
                    end
                end
                SWEEP: begin
                    if (sweep_last) begin
                        state_reg    <= DONE;
                        busy_reg     <= 1'b0;
                        clr_done_reg <= 1'b1;
                    end else begin
                        idx_reg <= idx_reg + ADDR_W'(1);
                    end
                end
                DONE: begin
                    state_reg    <= IDLE;
                    busy_reg     <= 1'b0;
                    clr_done_reg <= 1'b0;
                end
                default: begin
                    state_reg    <= IDLE;
                    busy_reg     <= 1'b0;
                    clr_done_reg <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = busy_reg;
    assign clr_done = clr_done_reg;

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_entry
        if (ZERO_REG && (gi == 0)) begin : g_zero
            assign entry_flat[gi] = '0;
        end else begin : g_store
            logic [DATA_W-1:0] entry_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    entry_reg <= '0;
                end else if ((state_reg == SWEEP) && (idx_reg == ADDR_W'(gi))) begin
                    entry_reg <= '0;
                end else if (wr_commit && (waddr == ADDR_W'(gi))) begin
                    entry_reg <= wdata;
                end
            end

            assign entry_flat[gi] = entry_reg;
        end
    end

    logic [1:0][ADDR_W-1:0] raddr_arr;
    logic [1:0][DATA_W-1:0] rdata_arr;

    assign raddr_arr = {raddr_b, raddr_a};

    // Outside IDLE the file is logically empty, so both ports read zero.
    for (genvar gi = 0; gi < 2; gi++) begin : g_rport
        logic [DATA_W-1:0] rd_next;

        always_comb begin
            rd_next = '0;
            if (is_idle && addr_in_range(raddr_arr[gi]) && !addr_is_zero_reg(raddr_arr[gi])) begin
                if (BYPASS && wr_fwd && (waddr == raddr_arr[gi])) begin
                    rd_next = wdata;
                end else begin
                    rd_next = entry_flat[raddr_arr[gi]];
                end
            end
        end

        assign rdata_arr[gi] = rd_next;
    end

    assign rdata_a = rdata_arr[0];
    assign rdata_b = rdata_arr[1];

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: default, no-bypass and zero-entry instances share one stimulus stream.
module tb_reg_file;

    localparam int DW = 8;
    localparam int NR = 8;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          we;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic [AW-1:0] raddr_a;
    logic [AW-1:0] raddr_b;
    logic          clr_req;

    logic [DW-1:0] rda_d, rdb_d, rda_nb, rdb_nb, rda_z, rdb_z;
    logic          busy_d, done_d, busy_nb, done_nb, busy_z, done_z;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reg_file #(.DATA_W(DW), .NUM_REGS(NR), .ZERO_REG(1'b0), .BYPASS(1'b1)) dut (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .rdata_a(rda_d), .raddr_b(raddr_b), .rdata_b(rdb_d),
        .clr_req(clr_req), .busy(busy_d), .clr_done(done_d)
    );

    reg_file #(.DATA_W(DW), .NUM_REGS(NR), .ZERO_REG(1'b0), .BYPASS(1'b0)) dut_nb (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .rdata_a(rda_nb), .raddr_b(raddr_b), .rdata_b(rdb_nb),
        .clr_req(clr_req), .busy(busy_nb), .clr_done(done_nb)
    );

    reg_file #(.DATA_W(DW), .NUM_REGS(NR), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut_z (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .rdata_a(rda_z), .raddr_b(raddr_b), .rdata_b(rdb_z),
        .clr_req(clr_req), .busy(busy_z), .clr_done(done_z)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [AW-1:0] a, input logic [DW-1:0] d);
        we    = 1'b1;
        waddr = a;
        wdata = d;
        tick();
        we    = 1'b0;
        $display("txn write r%0d = 0x%02h", a, d);
    endtask

    task automatic test_reset();
        rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
        raddr_a = '0; raddr_b = '0; clr_req = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (busy_d !== 1'b0) begin
            errors++; $display("FAIL reset_busy: got %b expected 0", busy_d);
        end
        checks++;
        if (done_d !== 1'b0) begin
            errors++; $display("FAIL reset_done: got %b expected 0", done_d);
        end
        for (int i = 0; i < NR; i++) begin
            raddr_a = AW'(i);
            #1;
            checks++;
            if (rda_d !== 8'h00) begin
                errors++; $display("FAIL reset_entry r%0d: got 0x%02h expected 0x00", i, rda_d);
            end
        end
        $display("txn reset done");
    endtask

    task automatic test_write_read();
        logic [DW-1:0] exp;
        write_reg(3'd3, 8'hA5);
        write_reg(3'd5, 8'h3C);
        raddr_a = 3'd3; raddr_b = 3'd5;
        #1;
        checks++;
        if (rda_d !== 8'hA5) begin
            errors++; $display("FAIL read_a_r3: got 0x%02h expected 0xa5", rda_d);
        end
        checks++;
        if (rdb_d !== 8'h3C) begin
            errors++; $display("FAIL read_b_r5: got 0x%02h expected 0x3c", rdb_d);
        end
        for (int i = 0; i < NR; i++) begin
            raddr_b = AW'(i);
            exp = (i == 3) ? 8'hA5 : (i == 5) ? 8'h3C : 8'h00;
            #1;
            checks++;
            if (rdb_d !== exp) begin
                errors++; $display("FAIL read_all r%0d: got 0x%02h expected 0x%02h", i, rdb_d, exp);
            end
        end
        raddr_a = 3'd5; raddr_b = 3'd5;
        #1;
        checks++;
        if (rda_d !== 8'h3C || rdb_d !== 8'h3C) begin
            errors++; $display("FAIL same_addr: got a=0x%02h b=0x%02h expected 0x3c", rda_d, rdb_d);
        end
    endtask

    task automatic test_bypass();
        write_reg(3'd2, 8'h11);
        we = 1'b1; waddr = 3'd2; wdata = 8'h77; raddr_a = 3'd2; raddr_b = 3'd3;
        #1;
        checks++;
        if (rda_d !== 8'h77) begin
            errors++; $display("FAIL bypass_on: got 0x%02h expected 0x77", rda_d);
        end
        checks++;
        if (rda_nb !== 8'h11) begin
            errors++; $display("FAIL bypass_off_old: got 0x%02h expected 0x11", rda_nb);
        end
        checks++;
        if (rdb_d !== 8'hA5) begin
            errors++; $display("FAIL bypass_other_port: got 0x%02h expected 0xa5", rdb_d);
        end
        tick();
        we = 1'b0;
        $display("txn write r2 = 0x77 (bypass cycle)");
        #1;
        checks++;
        if (rda_nb !== 8'h77) begin
            errors++; $display("FAIL bypass_off_next: got 0x%02h expected 0x77", rda_nb);
        end
        checks++;
        if (rda_d !== 8'h77) begin
            errors++; $display("FAIL bypass_on_next: got 0x%02h expected 0x77", rda_d);
        end
    endtask

    task automatic test_zero_reg();
        we = 1'b1; waddr = 3'd0; wdata = 8'hFF; raddr_a = 3'd0; raddr_b = 3'd2;
        #1;
        checks++;
        if (rda_z !== 8'h00) begin
            errors++; $display("FAIL zero_bypass: got 0x%02h expected 0x00", rda_z);
        end
        checks++;
        if (rda_d !== 8'hFF) begin
            errors++; $display("FAIL nonzero_bypass_r0: got 0x%02h expected 0xff", rda_d);
        end
        tick();
        we = 1'b0;
        $display("txn write r0 = 0xff");
        #1;
        checks++;
        if (rda_z !== 8'h00) begin
            errors++; $display("FAIL zero_after_write: got 0x%02h expected 0x00", rda_z);
        end
        checks++;
        if (rda_d !== 8'hFF) begin
            errors++; $display("FAIL nonzero_r0_stored: got 0x%02h expected 0xff", rda_d);
        end
        checks++;
        if (rdb_z !== 8'h77) begin
            errors++; $display("FAIL zero_inst_r2: got 0x%02h expected 0x77", rdb_z);
        end
    endtask

    task automatic test_clear();
        for (int i = 0; i < NR; i++) write_reg(AW'(i), 8'(8'h10 + i));
        clr_req = 1'b1; raddr_a = 3'd4; raddr_b = 3'd7;
        #1;
        checks++;
        if (rda_d !== 8'h14 || rdb_d !== 8'h17) begin
            errors++; $display("FAIL clr_req_cycle_reads: got a=0x%02h b=0x%02h expected 0x14/0x17", rda_d, rdb_d);
        end
        tick();
        clr_req = 1'b0;
        $display("txn clear request");
        for (int cyc = 0; cyc < 10; cyc++) begin
            we = (cyc == 3); waddr = 3'd4; wdata = 8'h99;
            raddr_a = AW'(cyc); raddr_b = 3'd4;
            #1;
            checks++;
            if (busy_d !== (cyc < 8) || done_d !== (cyc == 8)) begin
                errors++; $display("FAIL sweep_hs cyc%0d: got busy=%b done=%b expected busy=%b done=%b",
                                   cyc, busy_d, done_d, (cyc < 8), (cyc == 8));
            end
            checks++;
            if (rda_d !== 8'h00 || rdb_d !== 8'h00) begin
                errors++; $display("FAIL sweep_reads cyc%0d: got a=0x%02h b=0x%02h expected 0x00", cyc, rda_d, rdb_d);
            end
            tick();
        end
        we = 1'b0;
        for (int i = 0; i < NR; i++) begin
            raddr_a = AW'(i);
            #1;
            checks++;
            if (rda_d !== 8'h00) begin
                errors++; $display("FAIL after_clear r%0d: got 0x%02h expected 0x00", i, rda_d);
            end
        end
    endtask

    task automatic test_collision();
        int busy_cnt;
        int done_cnt;
        write_reg(3'd1, 8'h33);
        clr_req = 1'b1; we = 1'b1; waddr = 3'd1; wdata = 8'h55; raddr_a = 3'd1;
        #1;
        checks++;
        if (rda_d !== 8'h55) begin
            errors++; $display("FAIL collide_bypass: got 0x%02h expected 0x55", rda_d);
        end
        tick();
        clr_req = 1'b0; we = 1'b0;
        $display("txn clear request with write r1 = 0x55");
        busy_cnt = 0;
        done_cnt = 0;
        for (int cyc = 0; cyc < 14; cyc++) begin
            clr_req = (cyc == 2) || (cyc == 8);
            #1;
            busy_cnt += int'(busy_d);
            done_cnt += int'(done_d);
            tick();
        end
        clr_req = 1'b0;
        checks++;
        if (busy_cnt !== 8) begin
            errors++; $display("FAIL collide_busy_cycles: got %0d expected 8", busy_cnt);
        end
        checks++;
        if (done_cnt !== 1) begin
            errors++; $display("FAIL collide_done_pulses: got %0d expected 1", done_cnt);
        end
        raddr_a = 3'd1;
        #1;
        checks++;
        if (rda_d !== 8'h00) begin
            errors++; $display("FAIL collide_r1: got 0x%02h expected 0x00", rda_d);
        end
    endtask

    task automatic test_reset_mid();
        int done_cnt;
        write_reg(3'd2, 8'h22);
        write_reg(3'd7, 8'h77);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        tick();
        tick();
        tick();
        checks++;
        if (busy_d !== 1'b1) begin
            errors++; $display("FAIL mid_busy_before_rst: got %b expected 1", busy_d);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        $display("txn reset during sweep");
        checks++;
        if (busy_d !== 1'b0 || done_d !== 1'b0) begin
            errors++; $display("FAIL mid_rst_hs: got busy=%b done=%b expected 0/0", busy_d, done_d);
        end
        done_cnt = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            #1;
            done_cnt += int'(done_d);
            tick();
        end
        checks++;
        if (done_cnt !== 0) begin
            errors++; $display("FAIL mid_rst_done_pulses: got %0d expected 0", done_cnt);
        end
        for (int i = 0; i < NR; i++) begin
            raddr_a = AW'(i);
            #1;
            checks++;
            if (rda_d !== 8'h00) begin
                errors++; $display("FAIL mid_rst_entry r%0d: got 0x%02h expected 0x00", i, rda_d);
            end
        end
        write_reg(3'd6, 8'h42);
        raddr_a = 3'd6;
        #1;
        checks++;
        if (rda_d !== 8'h42) begin
            errors++; $display("FAIL mid_rst_write_r6: got 0x%02h expected 0x42", rda_d);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_bypass();
        test_zero_reg();
        test_clear();
        test_collision();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
